// File: rtl/rs232_recv_pkg.sv
// Shared definitions for the FT232 UART receiver: FSM states and baud-divider math.
// The transmitter uses the same helpers so both directions agree on bit timing.
package rs232_recv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;

   // Clocks per bit, rounded to nearest.
   function automatic int baud_div(input int clock_freq, input int baud_rate);
      return (clock_freq + baud_rate / 2) / baud_rate;
   endfunction

   function automatic int baud_half(input int clock_freq, input int baud_rate);
      return baud_div(clock_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for asynchronous idle-high serial control lines.
// Both flops come out of reset high so a quiet line never looks like a start edge.
module rs232_sync (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic synced
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta   <= 1'b1;
         synced <= 1'b1;
      end else begin
         meta   <= raw;
         synced <= meta;
      end
   end

endmodule

// File: rtl/rs232_recv.sv
// 8N1 UART receiver with a one-byte holding register on a valid/ready handshake.
// cts_n holds the host off while the holding register is occupied.
module rs232_recv
   import rs232_recv_pkg::*;
#(
   parameter int CLOCK_FREQ = 133000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic       cts_n,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_error,
   output logic       overrun
);

   localparam int DIV  = baud_div(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF = baud_half(CLOCK_FREQ, BAUD_RATE);
   localparam int CW   = $clog2(DIV);

   if (DIV < 4) begin : g_div_check
      $error("rs232_recv: clock-to-baud ratio must be at least 4");
   end

   logic          line;
   logic          line_prev;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          stop_hit;
   logic          load;
   logic          valid_next;

   rs232_sync u_sync (
      .clock  (clock),
      .reset  (reset),
      .raw    (rxd),
      .synced (line)
   );

   // A good stop bit may refill the holding register in the same cycle it is drained.
   always_comb begin
      stop_hit   = (state == ST_STOP) && (cnt == '0);
      load       = stop_hit && line && (!valid || ready);
      valid_next = load || (valid && !ready);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         line_prev   <= 1'b1;
         data        <= '0;
         valid       <= 1'b0;
         cts_n       <= 1'b1;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         line_prev   <= line;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         valid       <= valid_next;
         cts_n       <= valid_next;
         if (load) begin
            data <= shift;
         end

         case (state)
            ST_IDLE: begin
               if (line_prev && !line) begin
                  state <= ST_START;
                  cnt   <= CW'(HALF - 1);
               end
            end

            ST_START: begin
               if (cnt == '0) begin
                  if (line) begin
                     state <= ST_IDLE;
                  end else begin
                     state   <= ST_DATA;
                     cnt     <= CW'(DIV - 1);
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            ST_DATA: begin
               if (cnt == '0) begin
                  shift <= {line, shift[7:1]};
                  cnt   <= CW'(DIV - 1);
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            ST_STOP: begin
               // Back to IDLE right after the stop sample so back-to-back frames are caught.
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  if (!line) begin
                     frame_error <= 1'b1;
                  end else if (!load) begin
                     overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_recv.sv
// Self-checking bench for rs232_recv: a fast instance (16 clocks/bit) for most cases
// and a default-parameter instance for the exact end-to-end latency.
module tb_rs232_recv;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rxd_a = 1'b1;
   logic       ready_a = 1'b0;
   logic       cts_n_a;
   logic [7:0] data_a;
   logic       valid_a;
   logic       frame_error_a;
   logic       overrun_a;

   logic       rxd_b = 1'b1;
   logic       ready_b = 1'b1;
   logic       cts_n_b;
   logic [7:0] data_b;
   logic       valid_b;
   logic       frame_error_b;
   logic       overrun_b;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int fe_count = 0;
   int ov_count = 0;
   int valid_rises = 0;
   logic valid_prev = 1'b0;
   logic hold_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;
   logic [7:0] expq[$];

   typedef struct {
      logic [7:0] byte_val;
      logic       stop_bit;
      int         exp_fe;
      int         exp_valid;
   } vec_t;
   vec_t vecs[7];

   rs232_recv #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut_a (
      .clock       (clock),
      .reset       (reset),
      .rxd         (rxd_a),
      .cts_n       (cts_n_a),
      .data        (data_a),
      .valid       (valid_a),
      .ready       (ready_a),
      .frame_error (frame_error_a),
      .overrun     (overrun_a)
   );

   rs232_recv dut_b (
      .clock       (clock),
      .reset       (reset),
      .rxd         (rxd_b),
      .cts_n       (cts_n_b),
      .data        (data_b),
      .valid       (valid_b),
      .ready       (ready_b),
      .frame_error (frame_error_b),
      .overrun     (overrun_b)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard and pulse counters for the fast instance, sampled mid-cycle.
   always @(negedge clock) begin
      if (frame_error_a === 1'b1) fe_count++;
      if (overrun_a === 1'b1) ov_count++;
      if (valid_a === 1'b1 && valid_prev !== 1'b1) valid_rises++;
      if (valid_a === 1'b1 && hold_prev) begin
         checks++;
         if (data_a !== data_prev) begin
            errors++;
            $display("[TB] FAIL data_stable: got %02h, required %02h", data_a, data_prev);
         end
      end
      if (valid_a === 1'b1 && ready_a === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_pop: got byte %02h, required none", data_a);
         end else begin
            logic [7:0] exp_byte;
            exp_byte = expq.pop_front();
            if (data_a !== exp_byte) begin
               errors++;
               $display("[TB] FAIL scoreboard_data: got %02h, required %02h", data_a, exp_byte);
            end
         end
      end
      valid_prev = valid_a;
      hold_prev  = (valid_a === 1'b1) && (ready_a !== 1'b1);
      data_prev  = data_a;
   end

   initial begin
      repeat (60000) @(posedge clock);
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_cycle(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic at_neg(input int n);
      wait_cycle(n);
      @(negedge clock);
   endtask

   task automatic apply_stimulus(input logic [7:0] b, input logic stop, input int div,
                                 input bit sel);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (sel) rxd_b = bits[i];
         else     rxd_a = bits[i];
         repeat (div) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   initial begin
      int p, s, q, fe0, ov0, vr0;

      vecs[0] = '{8'h81, 1'b1, 0, 1};
      vecs[1] = '{8'h00, 1'b1, 0, 1};
      vecs[2] = '{8'hFF, 1'b1, 0, 1};
      vecs[3] = '{8'h5A, 1'b1, 0, 1};
      vecs[4] = '{8'h7E, 1'b0, 1, 0};
      vecs[5] = '{8'h01, 1'b1, 0, 1};
      vecs[6] = '{8'h80, 1'b1, 0, 1};

      // Reset values on both instances.
      idle(3);
      at_neg(cyc);
      check_output("rst_data_a",  data_a, 8'h00);
      check_output("rst_valid_a", valid_a, 1'b0);
      check_output("rst_cts_a",   cts_n_a, 1'b1);
      check_output("rst_fe_a",    frame_error_a, 1'b0);
      check_output("rst_ov_a",    overrun_a, 1'b0);
      check_output("rst_valid_b", valid_b, 1'b0);
      check_output("rst_cts_b",   cts_n_b, 1'b1);
      idle(1);
      reset = 1'b0;
      idle(4);
      check_output("cts_after_rst", cts_n_a, 1'b0);

      // Single byte with exact latency.
      ready_a = 1'b1;
      expq.push_back(8'h55);
      p = cyc;
      fork
         apply_stimulus(8'h55, 1'b1, 16, 1'b0);
         begin
            at_neg(p + 154);
            check_output("single_pre_valid", valid_a, 1'b0);
            at_neg(p + 155);
            check_output("single_valid", valid_a, 1'b1);
            check_output("single_data",  data_a, 8'h55);
            check_output("single_cts",   cts_n_a, 1'b1);
            at_neg(p + 156);
            check_output("single_valid_clr", valid_a, 1'b0);
            check_output("single_cts_clr",   cts_n_a, 1'b0);
         end
      join
      idle(10);

      // Backpressure: second byte dropped with an overrun pulse.
      ready_a = 1'b0;
      ov0 = ov_count;
      expq.push_back(8'hA5);
      apply_stimulus(8'hA5, 1'b1, 16, 1'b0);
      apply_stimulus(8'h3C, 1'b1, 16, 1'b0);
      idle(4);
      check_output("bp_valid",   valid_a, 1'b1);
      check_output("bp_data",    data_a, 8'hA5);
      check_output("bp_cts",     cts_n_a, 1'b1);
      check_output("bp_overrun", ov_count - ov0, 1);
      ready_a = 1'b1;
      q = cyc;
      at_neg(q + 1);
      check_output("bp_valid_clr", valid_a, 1'b0);
      check_output("bp_cts_clr",   cts_n_a, 1'b0);
      idle(10);

      // Accept and reload in the same cycle.
      ready_a = 1'b0;
      ov0 = ov_count;
      expq.push_back(8'hA5);
      expq.push_back(8'h3C);
      p = cyc;
      s = p + 160 + 2 + 152;
      fork
         begin
            apply_stimulus(8'hA5, 1'b1, 16, 1'b0);
            apply_stimulus(8'h3C, 1'b1, 16, 1'b0);
         end
         begin
            wait_cycle(s);
            ready_a = 1'b1;
            at_neg(s);
            check_output("same_valid0", valid_a, 1'b1);
            check_output("same_data0",  data_a, 8'hA5);
            at_neg(s + 1);
            check_output("same_valid1", valid_a, 1'b1);
            check_output("same_data1",  data_a, 8'h3C);
            check_output("same_cts1",   cts_n_a, 1'b1);
            at_neg(s + 2);
            check_output("same_valid2", valid_a, 1'b0);
         end
      join
      idle(4);
      check_output("same_no_overrun", ov_count - ov0, 0);

      // Framing error followed by a long break.
      fe0 = fe_count;
      vr0 = valid_rises;
      apply_stimulus(8'h00, 1'b0, 16, 1'b0);
      idle(640);
      rxd_a = 1'b1;
      idle(50);
      check_output("fe_pulses", fe_count - fe0, 1);
      check_output("fe_no_valid", valid_rises - vr0, 0);

      // Glitch rejection.
      fe0 = fe_count;
      rxd_a = 1'b0;
      idle(3);
      rxd_a = 1'b1;
      idle(40);
      check_output("glitch_fe", fe_count - fe0, 0);
      check_output("glitch_no_valid", valid_rises - vr0, 0);

      // Frame table, 0x81 first right after the glitch.
      for (int i = 0; i < 7; i++) begin
         fe0 = fe_count;
         vr0 = valid_rises;
         if (vecs[i].stop_bit) expq.push_back(vecs[i].byte_val);
         apply_stimulus(vecs[i].byte_val, vecs[i].stop_bit, 16, 1'b0);
         rxd_a = 1'b1;
         idle(20);
         check_output($sformatf("vec%0d_fe", i), fe_count - fe0, vecs[i].exp_fe);
         check_output($sformatf("vec%0d_valid", i), valid_rises - vr0, vecs[i].exp_valid);
      end
      check_output("scoreboard_empty", expq.size(), 0);

      // Reset in the middle of data bit 4.
      ready_a = 1'b0;
      fe0 = fe_count;
      ov0 = ov_count;
      vr0 = valid_rises;
      p = cyc;
      fork
         apply_stimulus(8'hF0, 1'b1, 16, 1'b0);
         begin
            wait_cycle(p + 16 * 5 + 8);
            reset = 1'b1;
            idle(2);
            at_neg(cyc);
            check_output("midrst_data",  data_a, 8'h00);
            check_output("midrst_valid", valid_a, 1'b0);
            check_output("midrst_cts",   cts_n_a, 1'b1);
            idle(1);
            reset = 1'b0;
         end
      join
      idle(30);
      check_output("midrst_no_valid", valid_rises - vr0, 0);
      check_output("midrst_no_fe",    fe_count - fe0, 0);
      check_output("midrst_no_ov",    ov_count - ov0, 0);

      // Default parameters: 0xC3 with exact t0-to-valid latency.
      p = cyc;
      fork
         apply_stimulus(8'hC3, 1'b1, 1155, 1'b1);
         begin
            at_neg(p + 2 + 577 + 9 * 1155);
            check_output("def_pre_valid", valid_b, 1'b0);
            at_neg(p + 2 + 577 + 9 * 1155 + 1);
            check_output("def_valid", valid_b, 1'b1);
            check_output("def_data",  data_b, 8'hC3);
            check_output("def_cts",   cts_n_b, 1'b1);
            at_neg(p + 2 + 577 + 9 * 1155 + 2);
            check_output("def_valid_clr", valid_b, 1'b0);
         end
      join
      idle(10);
      check_output("def_no_fe", frame_error_b, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
